// File: rtl/altavoz_pdm_if.sv
// Playback FIFO read port: the modulator pops one sample per fifo_rd strobe,
// with data returned on fifo_din one cycle later.
interface altavoz_pdm_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] fifo_din;
   logic              fifo_empty;
   logic              fifo_rd;

   modport master (
      input  fifo_din,
      input  fifo_empty,
      output fifo_rd
   );

   modport slave (
      output fifo_din,
      output fifo_empty,
      input  fifo_rd
   );
endinterface

// File: rtl/altavoz_pdm.sv
// PCM-to-PDM playback: pops unsigned samples from a FIFO and feeds them through
// a first-order sigma-delta modulator, one PDM bit every CLK_DIV clocks.
//
// state | meaning
// IDLE  | stopped, amplifier off, datapath cleared
// PRIME | fetching the first sample into cur
// RUN   | modulating cur, prefetching the next sample into nxt
module altavoz_pdm #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 50,
   parameter int OSR     = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   altavoz_pdm_if.master fifo,
   output logic          pdm_out,
   output logic          amp_sd,
   output logic          underrun,
   input  logic          clr_underrun,
   output logic          busy
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] cur_q, cur_d;
   logic [DATA_W-1:0] nxt_q, nxt_d;
   logic              nxt_valid_q, nxt_valid_d;
   logic              rd_pend_q, rd_pend_d;
   logic              pdm_q, pdm_d;
   logic              underrun_q, underrun_d;
   logic              rd_req;
   logic              tick;
   logic              ur_set;
   logic [DATA_W:0]   sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         acc_q       <= '0;
         cur_q       <= '0;
         nxt_q       <= '0;
         nxt_valid_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         pdm_q       <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         nxt_valid_q <= nxt_valid_d;
         rd_pend_q   <= rd_pend_d;
         pdm_q       <= pdm_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_PRIME;
         ST_PRIME: if (rd_pend_q) state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   // Reads are gated by enable so a stop never pops a sample it would discard.
   always_comb begin
      rd_req = 1'b0;
      amp_sd = 1'b0;
      busy   = (state_q != ST_IDLE);
      case (state_q)
         ST_PRIME: rd_req = enable && !fifo.fifo_empty && !rd_pend_q;
         ST_RUN: begin
            amp_sd = 1'b1;
            rd_req = enable && !fifo.fifo_empty && !rd_pend_q && !nxt_valid_q;
         end
         default: rd_req = 1'b0;
      endcase
   end

   assign fifo.fifo_rd = rd_req;
   assign pdm_out      = pdm_q;
   assign underrun     = underrun_q;

   always_comb begin
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      acc_d       = acc_q;
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      nxt_valid_d = nxt_valid_q;
      pdm_d       = pdm_q;
      rd_pend_d   = rd_req;
      ur_set      = 1'b0;
      sum         = {1'b0, acc_q} + {1'b0, cur_q};
      tick        = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);

      if (state_q == ST_RUN) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

      if (rd_pend_q) begin
         if (state_q == ST_PRIME) begin
            cur_d = fifo.fifo_din;
         end else if (state_q == ST_RUN) begin
            nxt_d       = fifo.fifo_din;
            nxt_valid_d = 1'b1;
         end
      end

      // A read landing on a boundary tick goes to nxt; nxt_valid_q is 0 then.
      if (tick) begin
         pdm_d = sum[DATA_W];
         acc_d = sum[DATA_W-1:0];
         if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (nxt_valid_q) begin
               cur_d       = nxt_q;
               nxt_valid_d = 1'b0;
            end else begin
               ur_set = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end

      underrun_d = ur_set | (underrun_q & ~clr_underrun);

      if (!enable) begin
         div_cnt_d   = '0;
         bit_cnt_d   = '0;
         acc_d       = '0;
         nxt_valid_d = 1'b0;
         rd_pend_d   = 1'b0;
         pdm_d       = 1'b0;
      end
   end
endmodule
